// File: rtl/fetch_predict_unit_if.sv
// Fetch-side bundle: instruction cache port, prediction carried into IF/ID,
// and branch resolution coming back from EX/MEM.
interface fetch_predict_unit_if;
    logic        ihit;
    logic        stall;
    logic        halt;
    logic [31:0] imemaddr;
    logic        imemREN;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic        mispredict;

    // Fetch unit side
    modport master (
        input  ihit, stall, halt,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
        input  resolve_pred_taken, resolve_pred_target,
        output imemaddr, imemREN, pred_taken, pred_target, mispredict
    );

    // Pipeline / cache side
    modport slave (
        output ihit, stall, halt,
        output resolve_valid, resolve_pc, resolve_taken, resolve_target,
        output resolve_pred_taken, resolve_pred_target,
        input  imemaddr, imemREN, pred_taken, pred_target, mispredict
    );
endinterface

// File: rtl/fetch_predict_unit.sv
// Registered PC with a direct-mapped BTB and saturating direction counters.
// Every fetch is predicted; EX/MEM resolution trains the BTB and flags mispredicts.
module fetch_predict_unit #(
    parameter logic [31:0] PC_INIT  = 32'h0,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input logic                  CLK,
    input logic                  nRST,
    fetch_predict_unit_if.master fif
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [31:0] pc_q, pc_d;
    logic        halt_q, halt_d;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [31:0]      pc_plus4;

    logic [IDX-1:0]   rs_idx;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_hit;
    logic [31:0]      redirect;

    logic                upd_en;
    logic                upd_tgt_we;
    logic [CTR_BITS-1:0] upd_ctr;

    assign lk_idx   = pc_q[IDX+1:2];
    assign lk_tag   = pc_q[31:IDX+2];
    assign pc_plus4 = pc_q + 32'd4;

    assign rs_idx   = fif.resolve_pc[IDX+1:2];
    assign rs_tag   = fif.resolve_pc[31:IDX+2];
    assign rs_hit   = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    assign redirect = fif.resolve_taken ? fif.resolve_target : fif.resolve_pc + 32'd4;

    assign fif.imemaddr = pc_q;
    assign fif.imemREN  = ~halt_q;

    assign fif.mispredict = fif.resolve_valid &
        ((fif.resolve_taken != fif.resolve_pred_taken) |
         (fif.resolve_taken & (fif.resolve_target != fif.resolve_pred_target)));

    // Prediction for the current PC from pre-edge BTB contents
    always_comb begin
        lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        fif.pred_taken  = lk_hit & ctr_q[lk_idx][CTR_BITS-1];
        fif.pred_target = fif.pred_taken ? target_q[lk_idx] : pc_plus4;
    end

    // Next PC: halt latch > mispredict redirect > stall > ihit advance
    always_comb begin
        pc_d   = pc_q;
        halt_d = halt_q | fif.halt;
        if (halt_q) begin
            pc_d = pc_q;
        end else if (fif.mispredict) begin
            pc_d = redirect;
        end else if (fif.stall) begin
            pc_d = pc_q;
        end else if (fif.ihit) begin
            pc_d = fif.pred_target;
        end
    end

    // BTB training: counter step on hit, weakly-taken allocation on taken miss
    always_comb begin
        upd_en     = fif.resolve_valid & ~halt_q & (rs_hit | fif.resolve_taken);
        upd_tgt_we = fif.resolve_taken;
        upd_ctr    = CTR_WEAK;
        if (rs_hit) begin
            if (fif.resolve_taken) begin
                upd_ctr = (ctr_q[rs_idx] == CTR_MAX) ? CTR_MAX : ctr_q[rs_idx] + 1'b1;
            end else begin
                upd_ctr = (ctr_q[rs_idx] == '0) ? '0 : ctr_q[rs_idx] - 1'b1;
            end
        end
    end

    // PC and sticky halt latch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q   <= PC_INIT;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
        end
    end

    // BTB storage; reset wipes every entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (upd_en) begin
            valid_q[rs_idx] <= 1'b1;
            tag_q[rs_idx]   <= rs_tag;
            ctr_q[rs_idx]   <= upd_ctr;
            if (upd_tgt_we) begin
                target_q[rs_idx] <= fif.resolve_target;
            end
        end
    end
endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed scenarios plus a
// randomized run against a behavioural model of the predictor.
module tb_fetch_predict_unit;
    localparam logic [31:0] PC_INIT  = 32'h0;
    localparam int          ENTRIES  = 16;
    localparam int          CTR_BITS = 2;
    localparam int          CTR_TOP  = (1 << CTR_BITS) - 1;
    localparam int          WEAK     = 1 << (CTR_BITS - 1);

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fetch_predict_unit_if fif();

    fetch_predict_unit #(
        .PC_INIT (PC_INIT),
        .ENTRIES (ENTRIES),
        .CTR_BITS(CTR_BITS)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .fif (fif)
    );

    always #5 CLK = ~CLK;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit exp_taken();
        return m_hit(m_pc) && (m_ctr[m_idx(m_pc)] >= WEAK);
    endfunction

    function automatic logic [31:0] exp_target();
        return exp_taken() ? m_tgt[m_idx(m_pc)] : m_pc + 32'd4;
    endfunction

    function automatic bit exp_mis();
        if (!fif.resolve_valid) return 1'b0;
        if (fif.resolve_taken != fif.resolve_pred_taken) return 1'b1;
        return fif.resolve_taken && (fif.resolve_target != fif.resolve_pred_target);
    endfunction

    task automatic m_reset();
        m_pc   = PC_INIT;
        m_halt = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        logic [31:0] nxt;
        int          k;
        nxt = m_pc;
        if (m_halt) nxt = m_pc;
        else if (exp_mis())
            nxt = fif.resolve_taken ? fif.resolve_target : fif.resolve_pc + 32'd4;
        else if (fif.stall) nxt = m_pc;
        else if (fif.ihit) nxt = exp_target();
        if (fif.resolve_valid && !m_halt) begin
            k = m_idx(fif.resolve_pc);
            if (m_hit(fif.resolve_pc)) begin
                if (fif.resolve_taken) begin
                    m_ctr[k] = (m_ctr[k] + 1 > CTR_TOP) ? CTR_TOP : m_ctr[k] + 1;
                    m_tgt[k] = fif.resolve_target;
                end else begin
                    m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (fif.resolve_taken) begin
                m_valid[k] = 1'b1;
                m_tag[k]   = m_tagof(fif.resolve_pc);
                m_tgt[k]   = fif.resolve_target;
                m_ctr[k]   = WEAK;
            end
        end
        m_halt = m_halt | fif.halt;
        m_pc   = nxt;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input bit ihit, input bit stall, input bit halt, input bit rv,
                          input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                          input bit rpt, input logic [31:0] rptgt);
        fif.ihit                = ihit;
        fif.stall               = stall;
        fif.halt                = halt;
        fif.resolve_valid       = rv;
        fif.resolve_pc          = rpc;
        fif.resolve_taken       = rt;
        fif.resolve_target      = rtgt;
        fif.resolve_pred_taken  = rpt;
        fif.resolve_pred_target = rptgt;
    endtask

    task automatic idle(input bit ihit);
        set_in(ihit, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Steer fetch to pc via a not-taken resolve that was predicted taken
    task automatic redirect_to(input logic [31:0] pc);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, pc - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
        #1;
        tick();
    endtask

    task automatic test_reset();
        idle(1'b0);
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (fif.imemaddr !== PC_INIT) begin
            failures++; $display("FAIL reset_addr got=%h exp=%h", fif.imemaddr, PC_INIT);
        end
        checks++;
        if (fif.imemREN !== 1'b1 || fif.pred_taken !== 1'b0 || fif.mispredict !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ren=%b pt=%b mis=%b exp 1 0 0",
                     fif.imemREN, fif.pred_taken, fif.mispredict);
        end
        checks++;
        if (fif.pred_target !== PC_INIT + 32'd4) begin
            failures++; $display("FAIL reset_ptgt got=%h exp=%h", fif.pred_target, PC_INIT + 4);
        end
        nRST = 1'b1;
        m_reset();
    endtask

    task automatic test_seq_fetch();
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fif.imemaddr !== 32'(4 * i) || fif.pred_taken !== 1'b0 || fif.imemREN !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch[%0d] got addr=%h pt=%b ren=%b exp addr=%h pt=0 ren=1",
                         i, fif.imemaddr, fif.pred_taken, fif.imemREN, 4 * i);
            end
            tick();
        end
    endtask

    task automatic test_taken_branch();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        checks++;
        if (fif.mispredict !== 1'b1) begin
            failures++; $display("FAIL first_taken_mis got=%b exp=1", fif.mispredict);
        end
        tick();
        idle(1'b1);
        #1;
        checks++;
        if (fif.imemaddr !== 32'h40) begin
            failures++; $display("FAIL first_taken_redirect got=%h exp=00000040", fif.imemaddr);
        end
        redirect_to(32'h10);
        idle(1'b1);
        #1;
        checks++;
        if (fif.pred_taken !== 1'b1 || fif.pred_target !== 32'h40) begin
            failures++;
            $display("FAIL trained_pred got pt=%b tgt=%h exp pt=1 tgt=00000040",
                     fif.pred_taken, fif.pred_target);
        end
        tick();
        #1;
        checks++;
        if (fif.imemaddr !== 32'h40) begin
            failures++; $display("FAIL follow_pred got=%h exp=00000040", fif.imemaddr);
        end
    endtask

    task automatic test_counter();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        checks++;
        if (fif.mispredict !== 1'b1) begin
            failures++; $display("FAIL not_taken_mis got=%b exp=1", fif.mispredict);
        end
        tick();
        idle(1'b0);
        #1;
        checks++;
        if (fif.imemaddr !== 32'h14) begin
            failures++; $display("FAIL not_taken_redirect got=%h exp=00000014", fif.imemaddr);
        end
        redirect_to(32'h10);
        idle(1'b0);
        #1;
        checks++;
        if (fif.pred_taken !== 1'b0 || fif.pred_target !== 32'h14) begin
            failures++;
            $display("FAIL weak_nt_pred got pt=%b tgt=%h exp pt=0 tgt=00000014",
                     fif.pred_taken, fif.pred_target);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
            #1;
            checks++;
            if (fif.pred_taken !== exp_taken() || fif.mispredict !== 1'b0) begin
                failures++;
                $display("FAIL train_up[%0d] got pt=%b mis=%b exp pt=%b mis=0",
                         i, fif.pred_taken, fif.mispredict, exp_taken());
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
        #1;
        tick();
        idle(1'b0);
        #1;
        checks++;
        if (fif.pred_taken !== 1'b1 || fif.pred_target !== 32'h40) begin
            failures++;
            $display("FAIL saturate_then_dec got pt=%b tgt=%h exp pt=1 tgt=00000040",
                     fif.pred_taken, fif.pred_target);
        end
    endtask

    task automatic test_alias();
        redirect_to(32'h50);
        idle(1'b0);
        #1;
        checks++;
        if (fif.pred_taken !== 1'b0 || fif.pred_target !== 32'h54) begin
            failures++;
            $display("FAIL alias got pt=%b tgt=%h exp pt=0 tgt=00000054",
                     fif.pred_taken, fif.pred_target);
        end
    endtask

    task automatic test_stall_mispredict();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 1'b1, 32'h80, 1'b0, 32'h64);
        #1;
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fif.imemaddr !== 32'h80) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h exp=00000080", i, fif.imemaddr);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        redirect_to(32'h20);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h90, 1'b0, 32'h14);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fif.imemREN !== 1'b0 || fif.imemaddr !== 32'h20) begin
                failures++;
                $display("FAIL halt_freeze[%0d] got ren=%b addr=%h exp ren=0 addr=00000020",
                         i, fif.imemREN, fif.imemaddr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle(1'b0);
        nRST = 1'b0;
        #1;
        checks++;
        if (fif.imemaddr !== PC_INIT || fif.imemREN !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got addr=%h ren=%b exp addr=%h ren=1",
                     fif.imemaddr, fif.imemREN, PC_INIT);
        end
        m_reset();
        #2;
        nRST = 1'b1;
        tick();
        idle(1'b1);
        repeat (4) tick();
        #1;
        checks++;
        if (fif.imemaddr !== 32'h10 || fif.pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL btb_cleared got addr=%h pt=%b exp addr=00000010 pt=0",
                     fif.imemaddr, fif.pred_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, rpc, rtgt, rptgt;
        bit          rt, rpt;
        for (int i = 0; i < 400; i++) begin
            r     = $urandom;
            rpc   = 32'($urandom_range(0, 63)) << 2;
            rtgt  = 32'($urandom_range(0, 63)) << 2;
            rt    = r[7];
            rpt   = r[6] ? rt : r[8];
            rptgt = r[5] ? rtgt : 32'($urandom_range(0, 63)) << 2;
            set_in(r[0] | r[1], r[2] & r[3], 1'b0, r[4], rpc, rt, rtgt, rpt, rptgt);
            #1;
            checks++;
            if (fif.imemaddr !== m_pc || fif.imemREN !== 1'b1) begin
                failures++;
                $display("FAIL rand_pc[%0d] got addr=%h ren=%b exp addr=%h ren=1",
                         i, fif.imemaddr, fif.imemREN, m_pc);
            end
            checks++;
            if (fif.pred_taken !== exp_taken() || fif.pred_target !== exp_target()) begin
                failures++;
                $display("FAIL rand_pred[%0d] got pt=%b tgt=%h exp pt=%b tgt=%h",
                         i, fif.pred_taken, fif.pred_target, exp_taken(), exp_target());
            end
            checks++;
            if (fif.mispredict !== exp_mis()) begin
                failures++;
                $display("FAIL rand_mis[%0d] got=%b exp=%b", i, fif.mispredict, exp_mis());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_taken_branch();
        test_counter();
        test_alias();
        test_stall_mispredict();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
Parametrised next-generation PC/fetch block for the 5-stage MIPS pipeline. It replaces the inline PC register and next-PC mux with a registered PC, a direct-mapped branch target buffer (BTB) and saturating direction counters. Every fetch is predicted, and mispredicts are detected from EX/MEM resolution information. It drives the instruction-side cache port and passes prediction bits into IF/ID for carriage down the pipe.

Parameters:
PC_INIT, 32'h0, reset value of PC
ENTRIES, 16, BTB entries; power of two, >=2; IDX = log2(ENTRIES)
CTR_BITS, 2, width of saturating direction counter, >=1

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction cache returned imemload this cycle
stall  in  1  hazard unit holds PC (IF/ID disabled)
halt  in  1  halt decoded/committed; sticky stop of fetch
imemaddr  out  32  current PC to instruction cache
imemREN  out  1  instruction read enable
pred_taken  out  1  prediction for current PC, latched into IF/ID with the instruction
pred_target  out  32  predicted target for current PC
resolve_valid  in  1  control-flow instruction resolved in EX/MEM this cycle
resolve_pc  in  32  PC of resolved instruction
resolve_taken  in  1  actual outcome (jumps always 1)
resolve_target  in  32  actual target (branch addr, jump addr, or rs for JR)
resolve_pred_taken  in  1  pred_taken carried with that instruction
resolve_pred_target  in  32  pred_target carried with that instruction
mispredict  out  1  flush request to hazard unit for IF/ID, ID/EX, EX/MEM

Behaviour:
- Reset (async, nRST=0): PC=PC_INIT; all BTB valid bits=0; all counters=0; halt latch=0. Outputs: imemaddr=PC_INIT, imemREN=1, pred_taken=0, pred_target=PC_INIT+4, mispredict=0. Reset mid-operation discards all BTB state.
- BTB indexing: index=pc[IDX+1:2]; tag=pc[31:IDX+2]; each entry holds valid, tag, target[31:0] and ctr[CTR_BITS-1:0].
- Lookup is combinational on the registered PC. hit = valid & tag match. pred_taken = hit & ctr[MSB]. pred_target = pred_taken ? entry target : PC+4, with 32-bit wrap on PC+4.
- mispredict (combinational) = resolve_valid & ((resolve_taken != resolve_pred_taken) | (resolve_taken & resolve_target != resolve_pred_target)).
- Redirect address = resolve_taken ? resolve_target : resolve_pc+4.
- PC update priority, evaluated per cycle:
  - halt latch set: hold PC.
  - mispredict: PC <= redirect, regardless of stall or ihit.
  - stall: hold PC.
  - ihit: PC <= pred_target.
  - otherwise: hold PC.
  - Latency: one cycle; the new PC appears on imemaddr in the cycle after the event.
- BTB update occurs on resolve_valid and while the halt latch is clear, on the clock edge:
  - Hit on resolve_pc: taken increments ctr (saturating at all-ones); not taken decrements ctr (saturating at 0); target is rewritten only when taken.
  - Miss and taken: allocate and overwrite the entry. valid=1, tag, target, ctr=2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no change.
- Simultaneous lookup and update of the same entry: lookup sees the pre-edge contents; the update is visible the next cycle.
- Halt: the halt input sets the latch at the edge. While latched, imemREN=0, PC is frozen and the BTB is frozen. Only reset clears the latch.
- Aliasing: a tag mismatch is a miss; no partial-tag prediction.

Test Plan:
1. Reset, then ihit=1 every cycle, no resolves -> imemaddr 0x0, 0x4, 0x8, 0xC; pred_taken=0; imemREN=1.
2. Taken branch, first encounter: resolve_valid=1, pc=0x10, taken=1, target=0x40, pred_taken=0 -> mispredict=1 in that cycle; next imemaddr=0x40. Later fetch at 0x10 -> pred_taken=1, pred_target=0x40; the following PC is 0x40.
3. Same branch (ctr=2) resolves not taken with pred_taken=1 -> mispredict=1, redirect 0x14, ctr=1. Next fetch of 0x10 -> pred_taken=0. Then three taken resolves -> ctr saturates at 3; one not-taken -> ctr=2; prediction is still taken.
4. Aliasing with ENTRIES=16: entry allocated for 0x10 (index 4); fetch 0x50 (index 4, different tag) -> pred_taken=0, pred_target=0x54.
5. Simultaneous events: stall=1 with a mispredict to 0x80 -> next imemaddr=0x80. Stall=1 alone -> PC held for every stalled cycle even with ihit=1.
6. Halt and reset: halt pulse at PC=0x20 -> imemREN=0 and PC stays 0x20 through later ihit/mispredict. nRST low mid-run -> imemaddr=PC_INIT immediately, and a previously trained branch is no longer predicted.
